fifo_mmio_bridge: RTL and testbench
===================================

Name: fifo_mmio_bridge

Overview:
Parametrised multi-channel bridge between the host MMIO register path (write strobe plus read address/response) and user logic.
- Each channel owns two internal FIFOs:
  - TX: host to user.
  - RX: user to host.
- Each channel exposes a data window, a status register, an overflow counter and a loopback control.
- Sits between the CL register decode and the user compute blocks (e.g. adders); replaces the fixed single-channel 32-bit FIFO glue.

Parameters:
DATA_W, 32, data width of FIFOs and MMIO data; must be 32.
NUM_CH, 2, channel count, 1..8.
FIFO_DEPTH, 16, entries per FIFO; power of 2, 2..128.
BASE_ADDR, 32'h0000_0600, address of channel 0; channel c base = BASE_ADDR + 16*c.

Ports:
clk_main_a0  in  1  clock
rst_main_n_sync  in  1  reset; asynchronous, active-low
wready  in  1  one-cycle host write strobe
wr_addr  in  32  host write address
wdata  in  32  host write data
arvalid_q  in  1  host read request
araddr_q  in  32  host read address
arready  out  1  read request accepted; high only in IDLE
rvalid  out  1  read response valid
rready  in  1  host accepts response
rdata  out  32  read response data
rresp  out  2  2'b00 OKAY, 2'b10 SLVERR
u_out_valid  out  NUM_CH  TX FIFO head valid, per channel
u_out_ready  in  NUM_CH  user pops TX FIFO
u_out_data  out  NUM_CH*32  TX FIFO head data (FWFT); channel c at [32c+31:32c]
u_in_valid  in  NUM_CH  user pushes RX FIFO
u_in_ready  out  NUM_CH  equals !rx_full[c]
u_in_data  in  NUM_CH*32  RX push data

Behaviour:
Reset (asynchronous):
- All FIFOs emptied; counters, loopback bits and state cleared; state = IDLE.
- rvalid=0, rdata=0, rresp=0.
- Reset asserted mid-read drops any pending response; no pop side effect is retained.

Per-channel register map (offset from channel base):
- +0x0 DATA:
  - Write pushes wdata into TX.
  - Read pops RX.
- +0x4 STATUS (read-only):
  - bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty.
  - [15:8] tx_count, [23:16] rx_count.
  - bit31 overflow sticky (ovf_cnt != 0).
- +0x8 CTRL:
  - bit0 loopback.
  - Read/write.
- +0xC OVF:
  - Read returns the 16-bit saturating count of dropped DATA writes, zero-extended.
  - Any write clears it.

Writes:
- Decoded in the cycle wready=1.
- DATA write when TX is full: dropped; ovf_cnt increments, saturating at 16'hFFFF.
- Fullness is sampled at the start of the cycle. A same-cycle user pop does not rescue the write.
- Writes to unmapped addresses are ignored.

FIFOs:
- FWFT; count width clog2(FIFO_DEPTH)+1.
- Simultaneous push and pop when non-empty and non-full: count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Read FSM:
- IDLE:
  - arready=1.
  - On arvalid_q, latch the address and decode.
  - DATA read with RX non-empty: pop RX this cycle, capture head into rdata → RESP.
  - DATA read with RX empty: rdata=32'hDEAD_0000|c, rresp=2'b10, no pop → RESP.
  - STATUS, CTRL or OVF read: capture value, rresp=00 → RESP.
  - Unmapped address: rdata=32'hAAAA_AAAA, rresp=2'b10 → RESP.
- RESP:
  - rvalid=1; rdata and rresp held stable until rready.
  - On rvalid&rready: rvalid=0 → IDLE.
- Latency: rvalid is asserted on the cycle after acceptance. Back-to-back reads need at least 2 cycles each.
- A host pop and a user push on the same RX in the same cycle both take effect.

Optional Feature:
FIFO_BRIDGE_LOOPBACK_EN
- Defined, with CTRL bit0 of channel c set:
  - TX head is moved into RX whenever TX is non-empty and RX is not full (one word per cycle).
  - u_out_valid[c]=0.
  - u_in_ready[c]=0.
- Defined, with CTRL bit0 clear: normal user ports operate.
- Not defined:
  - CTRL reads as 0 and writes are ignored.
  - The loopback mux is absent.

Test Plan:
- Reset, then write ch0 DATA 32'h1234_5678; user pops → u_out_data[31:0]=32'h1234_5678 while u_out_valid[0]=1; after the pop, STATUS reads tx_empty=1.
- User pushes 3 words into ch1 RX; host reads ch1 DATA three times → words returned in order, rresp=00; fourth read → rdata=32'hDEAD_0001, rresp=10.
- Write ch0 DATA FIFO_DEPTH+2 times with no pops → OVF reads 2 and STATUS bit31=1; write OVF → reads 0.
- Hold rready=0 for 5 cycles after a read → rvalid and rdata stable and arready=0 throughout; a second arvalid_q is not accepted until after the handshake.
- With FIFO_BRIDGE_LOOPBACK_EN defined and CTRL=1, write 32'hCAFE_0001 to ch0 DATA → next ch0 DATA read returns 32'hCAFE_0001; u_out_valid[0] stays 0.
- Assert rst_main_n_sync while in RESP with RX holding 2 words → rvalid=0 immediately; after release, STATUS reads rx_empty=1, counts 0.

Source files
------------

// File: rtl/fifo_mmio_bridge.sv
// fifo_mmio_bridge: multi-channel MMIO bridge with a TX (host->user) and RX (user->host) FWFT FIFO per channel.
// Optional per-channel TX->RX loopback is compiled in when FIFO_BRIDGE_LOOPBACK_EN is defined.
module fifo_mmio_bridge #(
    parameter int          DATA_W     = 32,
    parameter int          NUM_CH     = 2,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0600
) (
    input  logic                     clk_main_a0,
    input  logic                     rst_main_n_sync,
    input  logic                     wready,
    input  logic [31:0]              wr_addr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     arvalid_q,
    input  logic [31:0]              araddr_q,
    output logic                     arready,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [DATA_W-1:0]        rdata,
    output logic [1:0]               rresp,
    output logic [NUM_CH-1:0]        u_out_valid,
    input  logic [NUM_CH-1:0]        u_out_ready,
    output logic [NUM_CH*DATA_W-1:0] u_out_data,
    input  logic [NUM_CH-1:0]        u_in_valid,
    output logic [NUM_CH-1:0]        u_in_ready,
    input  logic [NUM_CH*DATA_W-1:0] u_in_data
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {S_IDLE, S_RESP} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    logic [NUM_CH-1:0] rd_hit;
    logic [NUM_CH-1:0] rx_empty;
    logic [NUM_CH-1:0] host_pop;
    logic [DATA_W-1:0] rx_head [NUM_CH];
    logic [31:0]       status  [NUM_CH];
    logic [31:0]       ctrl_rd [NUM_CH];
    logic [15:0]       ovf_rd  [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [31:0] CH_BASE = BASE_ADDR + 32'(16 * c);

        logic [DATA_W-1:0] tx_mem_q [FIFO_DEPTH];
        logic [DATA_W-1:0] rx_mem_q [FIFO_DEPTH];
        logic [AW-1:0]     tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
        logic [CW-1:0]     tx_cnt_q, rx_cnt_q;
        logic [15:0]       ovf_q;
        logic              tx_full, tx_empty, rx_full, wr_hit;
        logic              tx_push, tx_pop, rx_push, rx_pop;
        logic [DATA_W-1:0] rx_wdata;

        assign tx_full     = (tx_cnt_q == CW'(FIFO_DEPTH));
        assign tx_empty    = (tx_cnt_q == '0);
        assign rx_full     = (rx_cnt_q == CW'(FIFO_DEPTH));
        assign rx_empty[c] = (rx_cnt_q == '0);

        assign wr_hit    = wready && (wr_addr[31:4] == CH_BASE[31:4]) && (wr_addr[1:0] == 2'b00);
        assign rd_hit[c] = (araddr_q[31:4] == CH_BASE[31:4]) && (araddr_q[1:0] == 2'b00);

        // Fullness is the registered count, so a same-cycle user pop never rescues a write.
        assign tx_push = wr_hit && (wr_addr[3:2] == 2'd0) && !tx_full;
        assign rx_pop  = host_pop[c];

`ifdef FIFO_BRIDGE_LOOPBACK_EN
        logic lb_q;

        always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
            if (!rst_main_n_sync) begin
                lb_q <= 1'b0;
            end else if (wr_hit && (wr_addr[3:2] == 2'd2)) begin
                lb_q <= wdata[0];
            end
        end

        assign ctrl_rd[c]     = {31'd0, lb_q};
        assign tx_pop         = lb_q ? (!tx_empty && !rx_full) : (u_out_ready[c] && !tx_empty);
        assign rx_push        = lb_q ? (!tx_empty && !rx_full) : (u_in_valid[c] && !rx_full);
        assign rx_wdata       = lb_q ? tx_mem_q[tx_rp_q] : u_in_data[c*DATA_W +: DATA_W];
        assign u_out_valid[c] = !lb_q && !tx_empty;
        assign u_in_ready[c]  = !lb_q && !rx_full;
`else
        assign ctrl_rd[c]     = '0;
        assign tx_pop         = u_out_ready[c] && !tx_empty;
        assign rx_push        = u_in_valid[c] && !rx_full;
        assign rx_wdata       = u_in_data[c*DATA_W +: DATA_W];
        assign u_out_valid[c] = !tx_empty;
        assign u_in_ready[c]  = !rx_full;
`endif

        always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
            if (!rst_main_n_sync) begin
                tx_wp_q  <= '0;
                tx_rp_q  <= '0;
                rx_wp_q  <= '0;
                rx_rp_q  <= '0;
                tx_cnt_q <= '0;
                rx_cnt_q <= '0;
                ovf_q    <= '0;
            end else begin
                if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
                if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
                if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
                if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
                tx_cnt_q <= tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
                rx_cnt_q <= rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
                if (wr_hit && (wr_addr[3:2] == 2'd3)) begin
                    ovf_q <= '0;
                end else if (wr_hit && (wr_addr[3:2] == 2'd0) && tx_full && (ovf_q != 16'hFFFF)) begin
                    ovf_q <= ovf_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk_main_a0) begin
            if (tx_push) tx_mem_q[tx_wp_q] <= wdata;
            if (rx_push) rx_mem_q[rx_wp_q] <= rx_wdata;
        end

        assign u_out_data[c*DATA_W +: DATA_W] = tx_mem_q[tx_rp_q];
        assign rx_head[c] = rx_mem_q[rx_rp_q];
        assign ovf_rd[c]  = ovf_q;
        assign status[c]  = {(ovf_q != 16'd0), 7'd0, 8'(rx_cnt_q), 8'(tx_cnt_q),
                             4'd0, rx_empty[c], rx_full, tx_empty, tx_full};
    end

    // Read path: decode and capture on acceptance, hold the response until rready.
    always_comb begin
        state_d  = state_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        host_pop = '0;
        case (state_q)
            S_IDLE: begin
                if (arvalid_q) begin
                    state_d = S_RESP;
                    rdata_d = 32'hAAAA_AAAA;
                    rresp_d = 2'b10;
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        if (rd_hit[ch]) begin
                            rresp_d = 2'b00;
                            case (araddr_q[3:2])
                                2'd0: begin
                                    if (rx_empty[ch]) begin
                                        rdata_d = 32'hDEAD_0000 | 32'(ch);
                                        rresp_d = 2'b10;
                                    end else begin
                                        rdata_d      = rx_head[ch];
                                        host_pop[ch] = 1'b1;
                                    end
                                end
                                2'd1:    rdata_d = status[ch];
                                2'd2:    rdata_d = ctrl_rd[ch];
                                default: rdata_d = {16'd0, ovf_rd[ch]};
                            endcase
                        end
                    end
                end
            end
            S_RESP: begin
                if (rready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            state_q <= S_IDLE;
            rdata_q <= '0;
            rresp_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
        end
    end

    assign arready = (state_q == S_IDLE);
    assign rvalid  = (state_q == S_RESP);
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

endmodule

// File: tb/tb_fifo_mmio_bridge.sv
// Bench for fifo_mmio_bridge: queue-based reference model checked every cycle plus directed literal checks.
// Loopback section follows FIFO_BRIDGE_LOOPBACK_EN the same way as the design.
module tb_fifo_mmio_bridge;
    localparam int          NCH   = 2;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_0600;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               wready;
    logic [31:0]        wr_addr;
    logic [31:0]        wdata;
    logic               arvalid_q;
    logic [31:0]        araddr_q;
    logic               arready;
    logic               rvalid;
    logic               rready;
    logic [31:0]        rdata;
    logic [1:0]         rresp;
    logic [NCH-1:0]     u_out_valid;
    logic [NCH-1:0]     u_out_ready;
    logic [NCH*32-1:0]  u_out_data;
    logic [NCH-1:0]     u_in_valid;
    logic [NCH-1:0]     u_in_ready;
    logic [NCH*32-1:0]  u_in_data;

    always #5 clk = ~clk;

    fifo_mmio_bridge #(
        .DATA_W(32), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)
    ) dut (
        .clk_main_a0(clk), .rst_main_n_sync(rst_n),
        .wready(wready), .wr_addr(wr_addr), .wdata(wdata),
        .arvalid_q(arvalid_q), .araddr_q(araddr_q), .arready(arready),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .u_out_valid(u_out_valid), .u_out_ready(u_out_ready), .u_out_data(u_out_data),
        .u_in_valid(u_in_valid), .u_in_ready(u_in_ready), .u_in_data(u_in_data)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain queues per channel, one response slot.
    logic [31:0] m_tx [NCH][$];
    logic [31:0] m_rx [NCH][$];
    bit [15:0]   m_ovf [NCH];
    bit          m_lb  [NCH];
    bit          m_pend = 1'b0;
    bit [31:0]   m_rdata = '0;
    bit [1:0]    m_rresp = '0;

    function automatic bit in_window(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(16 * NCH)) && (a[1:0] == 2'b00);
    endfunction

    function automatic void model_step();
        int szt [NCH];
        int szr [NCH];
        bit upop [NCH];
        bit lbmv [NCH];
        bit upush [NCH];
        bit hpop [NCH];
        bit hpush [NCH];
        logic [31:0] v;
        int ch;
        int off;
        for (int c = 0; c < NCH; c++) begin
            szt[c]   = m_tx[c].size();
            szr[c]   = m_rx[c].size();
            upop[c]  = !m_lb[c] && u_out_ready[c] && (szt[c] > 0);
            lbmv[c]  = m_lb[c] && (szt[c] > 0) && (szr[c] < DEPTH);
            upush[c] = !m_lb[c] && u_in_valid[c] && (szr[c] < DEPTH);
            hpop[c]  = 1'b0;
            hpush[c] = 1'b0;
        end
        if (m_pend) begin
            if (rready) m_pend = 1'b0;
        end else if (arvalid_q) begin
            m_pend  = 1'b1;
            m_rdata = 32'hAAAA_AAAA;
            m_rresp = 2'b10;
            if (in_window(araddr_q)) begin
                ch  = int'((araddr_q - BASE) / 16);
                off = int'((araddr_q - BASE) % 16);
                m_rresp = 2'b00;
                if (off == 0) begin
                    if (szr[ch] == 0) begin
                        m_rdata = 32'hDEAD_0000 + 32'(ch);
                        m_rresp = 2'b10;
                    end else begin
                        m_rdata  = m_rx[ch][0];
                        hpop[ch] = 1'b1;
                    end
                end else if (off == 4) begin
                    m_rdata = (m_ovf[ch] != 0 ? 32'h8000_0000 : 32'h0)
                            + 32'(szr[ch]) * 65536 + 32'(szt[ch]) * 256
                            + (szr[ch] == 0 ? 32'd8 : 32'd0) + (szr[ch] == DEPTH ? 32'd4 : 32'd0)
                            + (szt[ch] == 0 ? 32'd2 : 32'd0) + (szt[ch] == DEPTH ? 32'd1 : 32'd0);
                end else if (off == 8) begin
                    m_rdata = m_lb[ch] ? 32'd1 : 32'd0;
                end else begin
                    m_rdata = 32'(m_ovf[ch]);
                end
            end
        end
        if (wready && in_window(wr_addr)) begin
            ch  = int'((wr_addr - BASE) / 16);
            off = int'((wr_addr - BASE) % 16);
            if (off == 0) begin
                if (szt[ch] == DEPTH) begin
                    if (m_ovf[ch] != 16'hFFFF) m_ovf[ch] = m_ovf[ch] + 16'd1;
                end else begin
                    hpush[ch] = 1'b1;
                end
            end else if (off == 8) begin
`ifdef FIFO_BRIDGE_LOOPBACK_EN
                m_lb[ch] = wdata[0];
`endif
            end else if (off == 12) begin
                m_ovf[ch] = 16'd0;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (hpop[c]) v = m_rx[c].pop_front();
            if (upop[c]) v = m_tx[c].pop_front();
            if (lbmv[c]) begin
                v = m_tx[c].pop_front();
                m_rx[c].push_back(v);
            end
            if (upush[c]) m_rx[c].push_back(u_in_data[c*32 +: 32]);
            if (hpush[c]) m_tx[c].push_back(wdata);
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                m_tx[c].delete();
                m_rx[c].delete();
                m_ovf[c] = 16'd0;
                m_lb[c]  = 1'b0;
            end
            m_pend  = 1'b0;
            m_rdata = '0;
            m_rresp = '0;
        end else begin
            model_step();
        end
    end

    always @(posedge clk) begin
        #1;
        chk("arready", 32'(arready), 32'(!m_pend));
        chk("rvalid", 32'(rvalid), 32'(m_pend));
        if (m_pend) begin
            chk("rdata", rdata, m_rdata);
            chk("rresp", 32'(rresp), 32'(m_rresp));
        end
        for (int c = 0; c < NCH; c++) begin
            chk("u_out_valid", 32'(u_out_valid[c]), 32'(!m_lb[c] && (m_tx[c].size() > 0)));
            chk("u_in_ready", 32'(u_in_ready[c]), 32'(!m_lb[c] && (m_rx[c].size() < DEPTH)));
            if (!m_lb[c] && (m_tx[c].size() > 0)) chk("u_out_data", u_out_data[c*32 +: 32], m_tx[c][0]);
        end
    end

    task automatic host_write(input logic [31:0] a, input logic [31:0] d);
        wready  = 1'b1;
        wr_addr = a;
        wdata   = d;
        @(negedge clk);
        wready  = 1'b0;
    endtask

    task automatic host_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!arready) chk("rd_arready_timeout", 32'(arready), 32'd1);
        arvalid_q = 1'b1;
        araddr_q  = a;
        @(negedge clk);
        arvalid_q = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rvalid) chk("rd_rvalid_timeout", 32'(rvalid), 32'd1);
        d = rdata;
        r = rresp;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        rst_n = 1'b0; wready = 1'b0; wr_addr = '0; wdata = '0;
        arvalid_q = 1'b0; araddr_q = '0; rready = 1'b1;
        u_out_ready = '0; u_in_valid = '0; u_in_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rresp", 32'(rresp), 32'd0);
        chk("rst_arready", 32'(arready), 32'd1);
        chk("rst_u_out_valid", 32'(u_out_valid), 32'd0);
        chk("rst_u_in_ready", 32'(u_in_ready), 32'd3);
        rst_n = 1'b1;
        @(negedge clk);

        host_write(BASE, 32'h1234_5678);
        chk("t1_valid", 32'(u_out_valid[0]), 32'd1);
        chk("t1_data", u_out_data[31:0], 32'h1234_5678);
        u_out_ready[0] = 1'b1;
        @(negedge clk);
        u_out_ready[0] = 1'b0;
        chk("t1_valid_popped", 32'(u_out_valid[0]), 32'd0);
        host_read(BASE + 32'h4, d, r);
        chk("t1_status", d, 32'h0000_000A);
        chk("t1_status_resp", 32'(r), 32'd0);

        for (int i = 0; i < 3; i++) begin
            u_in_valid[1] = 1'b1;
            u_in_data[63:32] = 32'hA000_0001 + 32'(i);
            @(negedge clk);
        end
        u_in_valid = '0;
        for (int i = 0; i < 3; i++) begin
            host_read(BASE + 32'h10, d, r);
            chk("t2_rx_word", d, 32'hA000_0001 + 32'(i));
            chk("t2_rx_resp", 32'(r), 32'd0);
        end
        host_read(BASE + 32'h10, d, r);
        chk("t2_empty_data", d, 32'hDEAD_0001);
        chk("t2_empty_resp", 32'(r), 32'd2);

        host_read(BASE + 32'h20, d, r);
        chk("unmapped_data", d, 32'hAAAA_AAAA);
        chk("unmapped_resp", 32'(r), 32'd2);
        host_write(BASE + 32'h20, 32'h7777_7777);
        chk("unmapped_write_ignored", 32'(u_out_valid), 32'd0);

        for (int i = 0; i < DEPTH + 2; i++) host_write(BASE, 32'h0B00_0000 + 32'(i));
        chk("t3_head", u_out_data[31:0], 32'h0B00_0000);
        host_read(BASE + 32'hC, d, r);
        chk("t3_ovf", d, 32'd2);
        chk("model_ovf", 32'(m_ovf[0]), 32'd2);
        host_read(BASE + 32'h4, d, r);
        chk("t3_status_full", d, 32'h8000_1009);
        host_write(BASE + 32'hC, 32'h0);
        host_read(BASE + 32'hC, d, r);
        chk("t3_ovf_cleared", d, 32'd0);
        host_read(BASE + 32'h4, d, r);
        chk("t3_status_clr", d, 32'h0000_1009);
        u_out_ready[0] = 1'b1;
        repeat (DEPTH) @(negedge clk);
        u_out_ready[0] = 1'b0;
        chk("t3_drained", 32'(u_out_valid[0]), 32'd0);

        u_in_valid[0] = 1'b1;
        u_in_data[31:0] = 32'h5555_0000;
        @(negedge clk);
        u_in_valid = '0;
        rready = 1'b0;
        araddr_q = BASE;
        arvalid_q = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_rvalid", 32'(rvalid), 32'd1);
            chk("t4_hold_rdata", rdata, 32'h5555_0000);
            chk("t4_hold_arready", 32'(arready), 32'd0);
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        chk("t4_after_hs_rvalid", 32'(rvalid), 32'd0);
        @(negedge clk);
        arvalid_q = 1'b0;
        chk("t4_second_rvalid", 32'(rvalid), 32'd1);
        chk("t4_second_rdata", rdata, 32'hDEAD_0000);
        chk("t4_second_rresp", 32'(rresp), 32'd2);
        @(negedge clk);

`ifdef FIFO_BRIDGE_LOOPBACK_EN
        host_write(BASE + 32'h8, 32'h1);
        host_read(BASE + 32'h8, d, r);
        chk("t5_ctrl", d, 32'd1);
        host_write(BASE, 32'hCAFE_0001);
        chk("t5_out_valid", 32'(u_out_valid[0]), 32'd0);
        chk("t5_in_ready", 32'(u_in_ready[0]), 32'd0);
        @(negedge clk);
        host_read(BASE, d, r);
        chk("t5_loop_data", d, 32'hCAFE_0001);
        chk("t5_loop_resp", 32'(r), 32'd0);
        host_write(BASE + 32'h8, 32'h0);
`else
        host_write(BASE + 32'h8, 32'h1);
        host_read(BASE + 32'h8, d, r);
        chk("t5_ctrl_zero", d, 32'd0);
        host_write(BASE, 32'hCAFE_0001);
        chk("t5_out_valid", 32'(u_out_valid[0]), 32'd1);
        chk("t5_out_data", u_out_data[31:0], 32'hCAFE_0001);
        u_out_ready[0] = 1'b1;
        @(negedge clk);
        u_out_ready[0] = 1'b0;
`endif

        for (int i = 0; i < 2; i++) begin
            u_in_valid[0] = 1'b1;
            u_in_data[31:0] = 32'hB000_0001 + 32'(i);
            @(negedge clk);
        end
        u_in_valid = '0;
        rready = 1'b0;
        araddr_q = BASE;
        arvalid_q = 1'b1;
        @(negedge clk);
        arvalid_q = 1'b0;
        chk("t6_resp_rvalid", 32'(rvalid), 32'd1);
        chk("t6_resp_rdata", rdata, 32'hB000_0001);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rvalid", 32'(rvalid), 32'd0);
        chk("t6_rst_arready", 32'(arready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        rready = 1'b1;
        @(negedge clk);
        host_read(BASE + 32'h4, d, r);
        chk("t6_status", d, 32'h0000_000A);
        host_read(BASE + 32'hC, d, r);
        chk("t6_ovf", d, 32'd0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
